// File: rtl/rgb_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_timing_pkg
// Purpose  : Shared RGB panel timing defaults, frame-size helper, pixel
//            bit-field layout and reader FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rgb_timing_pkg;

    // Default 800x480 panel timing (clocks / lines)
    localparam int c_h_active_def = 800;
    localparam int c_h_fp_def     = 40;
    localparam int c_h_sync_def   = 48;
    localparam int c_h_bp_def     = 40;
    localparam int c_v_active_def = 480;
    localparam int c_v_fp_def     = 13;
    localparam int c_v_sync_def   = 3;
    localparam int c_v_bp_def     = 29;

    // Pixel word layout on the SRAM data bus: {B, G, R}
    localparam int c_pix_w = 24;
    localparam int c_r_lsb = 0;
    localparam int c_g_lsb = 8;
    localparam int c_b_lsb = 16;

    // Total length of a line (in clocks) or of a frame (in lines)
    function automatic int line_total(input int act, input int fp,
                                      input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/rgb_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : rgb_timing_gen
// Purpose  : Horizontal/vertical raster counters with active, HS and VS
//            decode. Counters run only while i_run is high, otherwise they
//            are held at the frame origin.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_timing_gen
    import rgb_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active_def,
    parameter int H_FP     = c_h_fp_def,
    parameter int H_SYNC   = c_h_sync_def,
    parameter int H_BP     = c_h_bp_def,
    parameter int V_ACTIVE = c_v_active_def,
    parameter int V_FP     = c_v_fp_def,
    parameter int V_SYNC   = c_v_sync_def,
    parameter int V_BP     = c_v_bp_def
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_run,
    output logic o_frame_end,
    output logic o_act,
    output logic o_hs,
    output logic o_vs
);

    localparam int c_h_total = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);
    localparam int c_hs_beg  = H_ACTIVE + H_FP;
    localparam int c_hs_end  = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_vs_beg  = V_ACTIVE + V_FP;
    localparam int c_vs_end  = V_ACTIVE + V_FP + V_SYNC;

    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;
    logic            w_h_last;
    logic            w_v_last;

    assign w_h_last = (int'(r_h_cnt) == c_h_total - 1);
    assign w_v_last = (int'(r_v_cnt) == c_v_total - 1);

    // Raster scan: h wraps each line and advances v; v wraps each frame
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_frame_end = i_run && w_h_last && w_v_last;
    assign o_act = i_run && (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    assign o_hs  = i_run && (int'(r_h_cnt) >= c_hs_beg) && (int'(r_h_cnt) < c_hs_end);
    assign o_vs  = i_run && (int'(r_v_cnt) >= c_vs_beg) && (int'(r_v_cnt) < c_vs_end);

endmodule
`default_nettype wire

// File: rtl/sram_rgb_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_rgb_reader
// Purpose  : Streams a stored frame out of SRAM in raster order and drives
//            RGB panel timing. Read addresses are issued on active pixels;
//            strobes are delayed to line up with the SRAM read latency so
//            DE, syncs and pixel data reach the pins together.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rgb_reader
    import rgb_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active_def,
    parameter int H_FP     = c_h_fp_def,
    parameter int H_SYNC   = c_h_sync_def,
    parameter int H_BP     = c_h_bp_def,
    parameter int V_ACTIVE = c_v_active_def,
    parameter int V_FP     = c_v_fp_def,
    parameter int V_SYNC   = c_v_sync_def,
    parameter int V_BP     = c_v_bp_def,
    parameter int ADDR_W   = 19,
    parameter int READ_LAT = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Frame_Ready,
    input  logic [c_pix_w-1:0] Sram_Data,
    output logic [ADDR_W-1:0] Sram_Addr,
    output logic              Sram_OE_n,
    output logic              RGB_VSA_Inv,
    output logic              RGB_HSA_Inv,
    output logic              RGB_DE,
    output logic [7:0]        RGB_R,
    output logic [7:0]        RGB_G,
    output logic [7:0]        RGB_B,
    output logic              Frame_Start
);

    localparam logic [ADDR_W-1:0] c_last_pix = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    rd_state_t           r_state;
    logic                r_frame_start;
    logic                r_oe_n;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [READ_LAT-1:0] r_act_d;
    logic [READ_LAT-1:0] r_hs_d;
    logic [READ_LAT-1:0] r_vs_d;
    logic                r_de;
    logic                r_hs_n;
    logic                r_vs_n;
    logic [c_pix_w-1:0]  r_rgb;

    logic w_run;
    logic w_frame_end;
    logic w_act;
    logic w_hs;
    logic w_vs;

    assign w_run = (r_state == ST_RUN);

    rgb_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .Clock       (Clock),
        .Reset       (Reset),
        .i_run       (w_run),
        .o_frame_end (w_frame_end),
        .o_act       (w_act),
        .o_hs        (w_hs),
        .o_vs        (w_vs)
    );

    // Frame sequencing: Frame_Ready is only looked at in IDLE and at the
    // frame wrap, so a mid-frame drop always lets the frame finish
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_frame_start <= 1'b0;
            r_oe_n        <= 1'b1;
        end else begin
            r_frame_start <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (Frame_Ready) begin
                        r_state       <= ST_RUN;
                        r_frame_start <= 1'b1;
                        r_oe_n        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_frame_end) begin
                        if (Frame_Ready) begin
                            r_frame_start <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_oe_n  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_oe_n  <= 1'b1;
                end
            endcase
        end
    end

    // Linear read pointer: rewinds at every frame origin, saturates on the
    // last pixel so it never runs past the frame
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rd_ptr <= '0;
            r_addr   <= '0;
        end else if (!w_run || w_frame_end) begin
            r_rd_ptr <= '0;
        end else if (w_act) begin
            r_addr <= r_rd_ptr;
            if (r_rd_ptr != c_last_pix) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Strobe delay lines covering the address register plus SRAM latency
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_act_d <= '0;
            r_hs_d  <= '0;
            r_vs_d  <= '0;
        end else begin
            r_act_d[0] <= w_act;
            r_hs_d[0]  <= w_hs;
            r_vs_d[0]  <= w_vs;
            for (int i = 1; i < READ_LAT; i++) begin
                r_act_d[i] <= r_act_d[i-1];
                r_hs_d[i]  <= r_hs_d[i-1];
                r_vs_d[i]  <= r_vs_d[i-1];
            end
        end
    end

    // Output stage: capture SRAM data alongside the final strobe stage;
    // pixel data is blanked outside the active area
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_de   <= 1'b0;
            r_hs_n <= 1'b1;
            r_vs_n <= 1'b1;
            r_rgb  <= '0;
        end else begin
            r_de   <= r_act_d[READ_LAT-1];
            r_hs_n <= ~r_hs_d[READ_LAT-1];
            r_vs_n <= ~r_vs_d[READ_LAT-1];
            r_rgb  <= r_act_d[READ_LAT-1] ? Sram_Data : '0;
        end
    end

    assign Sram_Addr   = r_addr;
    assign Sram_OE_n   = r_oe_n;
    assign Frame_Start = r_frame_start;
    assign RGB_DE      = r_de;
    assign RGB_HSA_Inv = r_hs_n;
    assign RGB_VSA_Inv = r_vs_n;
    assign RGB_R       = r_rgb[c_r_lsb +: 8];
    assign RGB_G       = r_rgb[c_g_lsb +: 8];
    assign RGB_B       = r_rgb[c_b_lsb +: 8];

endmodule
`default_nettype wire

// File: doc/sram_rgb_reader.md
Name: sram_rgb_reader

Overview:
- Read-side counterpart of the DDT-to-SRAM write path.
- Once a full frame is in SRAM (Frame_Ready), the block generates RGB panel timing (VS/HS inverted, DE) and streams pixels out of SRAM in raster order.
- It issues linear read addresses, compensates the fixed SRAM read latency, and outputs aligned RGB_R/G/B with DE.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 48, HS pulse width (clocks)
- H_BP, 40, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, VS pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- ADDR_W, 19, SRAM address width
- READ_LAT, 2, clocks from Sram_Addr change to valid Sram_Data (1..4)

Ports:
- Clock  input  1  pixel clock; all registers update on falling edge
- Reset  input  1  asynchronous, active-low
- Frame_Ready  input  1  high = SRAM holds a complete frame; level, sampled once per frame
- Sram_Data  input  24  {B[7:0],G[7:0],R[7:0]} from SRAM
- Sram_Addr  output  ADDR_W  read address
- Sram_OE_n  output  1  SRAM output enable, active-low
- RGB_VSA_Inv  output  1  vertical sync, low during pulse
- RGB_HSA_Inv  output  1  horizontal sync, low during pulse
- RGB_DE  output  1  data enable
- RGB_R / RGB_G / RGB_B  output  8 each  pixel data, 0 when RGB_DE=0
- Frame_Start  output  1  one-clock pulse at h_cnt=0, v_cnt=0 of each RUN frame

Behaviour:
- Reset values:
  - Sram_Addr=0, Sram_OE_n=1
  - RGB_VSA_Inv=1, RGB_HSA_Inv=1, RGB_DE=0, RGB=0
  - Frame_Start=0, h_cnt=0, v_cnt=0, state=IDLE, all delay pipes cleared
- Constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h_cnt width = clog2(H_TOTAL); v_cnt width = clog2(V_TOTAL).
- Line layout in clocks: active [0,H_ACTIVE), FP, SYNC, BP. Frame layout in lines: same order.
- FSM:
  - IDLE: counters held at 0, syncs inactive, Sram_OE_n=1. Go to RUN when Frame_Ready=1.
  - RUN: h_cnt increments each clock and wraps at H_TOTAL-1 -> 0, incrementing v_cnt; v_cnt wraps at V_TOTAL-1 -> 0.
    - At wrap to (0,0), sample Frame_Ready: 1 = stay RUN and pulse Frame_Start; 0 = go to IDLE.
    - Frame_Ready dropping mid-frame has no effect; the frame always completes.
    - Entering RUN from IDLE pulses Frame_Start on the first RUN clock (h=0, v=0).
- Internal strobes (combinational from counters, RUN only):
  - act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Address:
  - Sram_Addr is registered: on a clock with act=1 it loads rd_ptr, and rd_ptr increments.
  - rd_ptr resets to 0 on each (0,0). Pixel k of a frame is at address k; last is H_ACTIVE*V_ACTIVE-1.
  - No wrap inside a frame; rd_ptr is never incremented past the last pixel.
  - Sram_OE_n = 0 throughout RUN.
- Latency:
  - Sram_Data for the address registered at edge n is captured into RGB at edge n+READ_LAT.
  - act, hs and vs each pass through a (READ_LAT+1)-stage delay so that RGB_DE, RGB_HSA_Inv=~hs_d and RGB_VSA_Inv=~vs_d align exactly with RGB data.
  - Total latency from counter state to pins = READ_LAT+1 clocks.
- RGB outputs are forced to 0 whenever the delayed act is 0.
- Transition RUN->IDLE: the pipeline drains with inactive values; pins read idle READ_LAT+1 clocks later.
- Asynchronous reset mid-frame: all state returns to reset values immediately. The next frame starts from (0,0) when Frame_Ready is 1.

Decomposition:
- Shared package (rgb_timing_pkg): H_/V_ timing defaults, H_TOTAL/V_TOTAL derivation, pixel bit-field positions (R=7:0, G=15:8, B=23:16), FSM state encoding.
- One sub-module: rgb_timing_gen, containing the h/v counters plus act/hs/vs decode.
- The reader top adds the FSM, address pointer, delay pipes and output registers.

Test Plan:
Small parameters for all cases: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, READ_LAT=2.
- Reset then Frame_Ready=0 for 100 clocks -> RGB_DE=0, both syncs=1, Sram_OE_n=1, Sram_Addr=0, no Frame_Start.
- Frame_Ready=1; SRAM model returns data = {addr,addr,addr} -> Frame_Start once per 48 clocks; each line gives RGB_DE high 4 clocks with R = 0,1,2,3 / 4..7 / 8..11. First RGB_DE comes 3 clocks after Frame_Start.
- Same run: per line, RGB_HSA_Inv is low 2 clocks, starting 5 clocks after the line's first DE. RGB_VSA_Inv is low for 8 clocks spanning line 4. DE=0 during lines 3-5.
- Frame_Ready deasserted at line 1 of frame 2 -> frame 2 completes all 12 pixels, then FSM returns to IDLE with no Frame_Start. Reasserting it restarts with Sram_Addr sequence from 0.
- Reset pulsed low at h=2, v=1 -> outputs return to reset values within the same clock; with Frame_Ready=1 the next frame restarts at address 0.
- READ_LAT=4 rerun of scenario 2 -> first RGB_DE comes 5 clocks after Frame_Start; data/DE/sync alignment unchanged.
